trng_multi_core: RTL

- Next-generation TRNG core: CHANNELS independent LFSR lanes, each perturbed by its own ring-oscillator entropy bit.
- Lane states are combined into words and buffered in a FIFO.
- Includes a repetition-count health test and sticky status flags.
- Sits behind the AXI4-lite slave controller on its BRAM-style port (en/we/addr/wrdata/rddata), replacing the single-lane TRNG datapath.

---
 rtl/trng_multi_core.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/trng_multi_core.sv
// trng_multi_core: multi-lane TRNG behind a BRAM-style register port.
// Each lane is a Galois LFSR that is perturbed by one synchronized ring-oscillator bit.
// Every WORD_STEPS ticks, the XOR of all lane states is pushed into a word FIFO.
// A per-lane repetition-count health test blocks pushes once any lane trips.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   en, we      - access strobe and byte write enables (any we bit = write)
//   addr        - byte address; addr[ADDR_W-1:4] picks the register
//   wrdata      - write data
//   rddata      - registered read data
//   entropy_in  - asynchronous oscillator bits, one per lane
//   osc_en      - oscillator enables (all bits equal)
//   irq         - level interrupt, irq_en & FIFO not empty

// One entropy lane: LFSR state plus its repetition-count health counter.
module trng_lane #(
   parameter int          WIDTH = 32,
   parameter logic [31:0] POLY  = 32'h80000370,
   parameter int          IDX   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             load,
   input  logic             cnt_clr,
   input  logic             ent,
   input  logic [WIDTH-1:0] seed,
   input  logic [7:0]       hlimit,
   output logic [WIDTH-1:0] state_nxt,
   output logic             hit
);
   logic [WIDTH-1:0] state_q, state_d, stepped;
   logic [7:0]       hcnt_q, hcnt_d;
   logic             last_q, last_d;

   always_comb begin
      stepped    = (state_q >> 1) ^ (state_q[0] ? POLY[WIDTH-1:0] : '0);
      stepped[0] = stepped[0] ^ ent;
      state_d    = state_q;
      if (load)      state_d = seed ^ WIDTH'(IDX);
      else if (tick) state_d = stepped;
      // An all-zero LFSR would never leave zero, so zero is replaced by 1.
      if (state_d == '0) state_d = WIDTH'(1);

      hcnt_d = hcnt_q;
      last_d = last_q;
      hit    = 1'b0;
      if (cnt_clr) hcnt_d = '0;
      else if (tick) begin
         last_d = ent;
         // A count of 0 means no previous sample exists, so the run restarts at 1.
         if (hcnt_q == 8'd0 || ent != last_q) hcnt_d = 8'd1;
         else if (hcnt_q != 8'hff)            hcnt_d = hcnt_q + 8'd1;
         hit = (hlimit != 8'd0) && (hcnt_d >= hlimit);
      end
   end

   assign state_nxt = state_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WIDTH'(IDX + 1);
         hcnt_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         last_q  <= last_d;
      end
   end
endmodule

module trng_multi_core #(
   parameter int             CHANNELS   = 4,
   parameter int             WIDTH      = 32,
   parameter logic [31:0]    POLY       = 32'h80000370,
   parameter int             FIFO_DEPTH = 16,
   parameter int             WIN_W      = 10,
   parameter logic [WIN_W-1:0] WIN_RESET = 10'd64,
   parameter int             WORD_STEPS = 32,
   parameter int             ADDR_W     = 13
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [3:0]          we,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [31:0]         wrdata,
   output logic [31:0]         rddata,
   input  logic [CHANNELS-1:0] entropy_in,
   output logic [CHANNELS-1:0] osc_en,
   output logic                irq
);
   localparam int SELW = ADDR_W - 4;
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int LW   = AW + 1;
   localparam int SW   = $clog2(WORD_STEPS + 1);
   localparam logic [SELW-1:0] R_DATA = SELW'(1), R_SEED = SELW'(2), R_CTRL = SELW'(3),
                               R_WIN  = SELW'(4), R_STAT = SELW'(5), R_HLIM = SELW'(6);

   logic [SELW-1:0] sel;
   logic wr, rd, ctrl_wr, win_wr, load, clr, run, cnt_hold, tick, push, push_ok, pop, rd_data;
   logic empty, full;
   logic [CHANNELS-1:0]             hit;
   logic [CHANNELS-1:0][WIDTH-1:0]  lane_nxt;
   logic [WIDTH-1:0]                lane_xor;
   logic [31:0]                     mem_q [FIFO_DEPTH];
   logic unused_ok;

   logic enable_q, enable_d, irq_en_q, irq_en_d, fail_q, fail_d, udf_q, udf_d, ovf_q, ovf_d;
   logic irq_q, irq_d;
   logic [31:0]         seed_q, seed_d, rddata_q, rddata_d;
   logic [WIN_W-1:0]    window_q, window_d, wcnt_q, wcnt_d;
   logic [7:0]          hlimit_q, hlimit_d;
   logic [SW-1:0]       step_q, step_d;
   logic [CHANNELS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LW-1:0]       level_q, level_d;

   assign unused_ok = ^addr[3:0];
   assign sel       = addr[ADDR_W-1:4];
   assign wr        = en & (|we);
   assign rd        = en & ~(|we);
   assign ctrl_wr   = wr && (sel == R_CTRL);
   assign win_wr    = wr && (sel == R_WIN);
   assign load      = ctrl_wr & wrdata[1];
   assign clr       = ctrl_wr & wrdata[2];
   assign run       = enable_q && (window_q != '0);
   // Dropping enable or rewriting WINDOW restarts the window without a tick.
   assign cnt_hold  = !run || win_wr || (ctrl_wr && !wrdata[0]);
   assign tick      = !cnt_hold && (wcnt_q == window_q - 1'b1);
   assign empty     = (level_q == '0);
   assign full      = (level_q == LW'(FIFO_DEPTH));
   assign rd_data   = rd && (sel == R_DATA);
   assign push      = tick && (step_q == SW'(WORD_STEPS - 1)) && !fail_q && !load && !clr;
   assign pop       = rd_data && !empty && !clr;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push_ok   = push && (!full || pop);
   assign osc_en    = {CHANNELS{run}};
   assign irq       = irq_q;
   assign rddata    = rddata_q;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      trng_lane #(.WIDTH(WIDTH), .POLY(POLY), .IDX(g)) u_lane (
         .clk      (clk),
         .rst      (rst),
         .tick     (tick),
         .load     (load),
         .cnt_clr  (load | clr),
         .ent      (sync2_q[g]),
         .seed     (seed_q[WIDTH-1:0]),
         .hlimit   (hlimit_q),
         .state_nxt(lane_nxt[g]),
         .hit      (hit[g])
      );
   end

   always_comb begin
      lane_xor = '0;
      for (int i = 0; i < CHANNELS; i++) lane_xor ^= lane_nxt[i];
   end

   always_comb begin
      enable_d = enable_q;
      irq_en_d = irq_en_q;
      seed_d   = seed_q;
      window_d = window_q;
      hlimit_d = hlimit_q;
      if (ctrl_wr) begin
         enable_d = wrdata[0];
         irq_en_d = wrdata[3];
      end
      if (wr && sel == R_SEED)
         for (int b = 0; b < 4; b++) if (we[b]) seed_d[8*b +: 8] = wrdata[8*b +: 8];
      if (win_wr)                window_d = wrdata[WIN_W-1:0];
      if (wr && sel == R_HLIM)   hlimit_d = wrdata[7:0];

      sync1_d = entropy_in;
      sync2_d = sync1_q;
      wcnt_d  = (cnt_hold || tick) ? '0 : wcnt_q + 1'b1;

      step_d = step_q;
      if (load || clr) step_d = '0;
      else if (tick)   step_d = (step_q == SW'(WORD_STEPS - 1)) ? '0 : step_q + 1'b1;

      fail_d = clr ? 1'b0 : (fail_q | (|hit));
      udf_d  = clr ? 1'b0 : (udf_q | (rd_data && empty));
      ovf_d  = clr ? 1'b0 : (ovf_q | (push && !push_ok));

      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (clr) begin
         wptr_d  = '0;
         rptr_d  = '0;
         level_d = '0;
      end else begin
         if (push_ok) wptr_d = wptr_q + 1'b1;
         if (pop)     rptr_d = rptr_q + 1'b1;
         if (push_ok && !pop)      level_d = level_q + 1'b1;
         else if (pop && !push_ok) level_d = level_q - 1'b1;
      end

      irq_d = irq_en_q & !empty;

      rddata_d = rddata_q;
      if (rd) begin
         case (sel)
            R_DATA:  rddata_d = empty ? 32'd0 : mem_q[rptr_q];
            R_SEED:  rddata_d = seed_q;
            R_CTRL:  rddata_d = {28'd0, irq_en_q, 2'b00, enable_q};
            R_WIN:   rddata_d = 32'(window_q);
            R_STAT:  rddata_d = {16'd0, 8'(level_q), 3'b000, fail_q, ovf_q, udf_q, full, empty};
            R_HLIM:  rddata_d = {24'd0, hlimit_q};
            default: rddata_d = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= 32'(lane_xor);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         enable_q <= 1'b0;
         irq_en_q <= 1'b0;
         seed_q   <= '0;
         window_q <= WIN_RESET;
         hlimit_q <= 8'd32;
         sync1_q  <= '0;
         sync2_q  <= '0;
         wcnt_q   <= '0;
         step_q   <= '0;
         fail_q   <= 1'b0;
         udf_q    <= 1'b0;
         ovf_q    <= 1'b0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         level_q  <= '0;
         irq_q    <= 1'b0;
         rddata_q <= '0;
      end else begin
         enable_q <= enable_d;
         irq_en_q <= irq_en_d;
         seed_q   <= seed_d;
         window_q <= window_d;
         hlimit_q <= hlimit_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         wcnt_q   <= wcnt_d;
         step_q   <= step_d;
         fail_q   <= fail_d;
         udf_q    <= udf_d;
         ovf_q    <= ovf_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         level_q  <= level_d;
         irq_q    <= irq_d;
         rddata_q <= rddata_d;
      end
   end
endmodule
